// File: rtl/ccd_pixel_capture_if.sv
// rtl/ccd_pixel_capture_if.sv - sensor-side inputs and pixel-stream outputs of ccd_pixel_capture
// Optional iTP_SEL member exists only when CAPTURE_TEST_PATTERN_EN is defined.
interface ccd_pixel_capture_if #(
    parameter int DATA_W = 12
);
    logic [DATA_W-1:0] iDATA;
    logic              iFVAL;
    logic              iLVAL;
    logic              iSTART;
    logic              iEND;
`ifdef CAPTURE_TEST_PATTERN_EN
    logic              iTP_SEL;
`endif
    logic [DATA_W-1:0] oDATA;
    logic              oDVAL;
    logic [15:0]       oX_Cont;
    logic [15:0]       oY_Cont;
    logic [31:0]       oFrame_Cont;
    logic              oBUSY;
    logic              oGEOM_ERR;

    modport master (
`ifdef CAPTURE_TEST_PATTERN_EN
        output iTP_SEL,
`endif
        output iDATA, iFVAL, iLVAL, iSTART, iEND,
        input  oDATA, oDVAL, oX_Cont, oY_Cont, oFrame_Cont, oBUSY, oGEOM_ERR
    );

    modport slave (
`ifdef CAPTURE_TEST_PATTERN_EN
        input  iTP_SEL,
`endif
        input  iDATA, iFVAL, iLVAL, iSTART, iEND,
        output oDATA, oDVAL, oX_Cont, oY_Cont, oFrame_Cont, oBUSY, oGEOM_ERR
    );
endinterface

// File: rtl/ccd_pixel_capture.sv
// rtl/ccd_pixel_capture.sv - CCD sensor timing to pixel stream with frame-aligned start/stop
// Define CAPTURE_TEST_PATTERN_EN to add the iTP_SEL (X+Y) test-pattern source.
module ccd_pixel_capture #(
    parameter int DATA_W  = 12,
    parameter int COL_MAX = 1280,
    parameter int ROW_MAX = 960
) (
    input  logic                 iCLK,
    input  logic                 iRST,
    ccd_pixel_capture_if.slave   bus
);
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_SOF = 2'd1,
        CAPTURE  = 2'd2
    } state_t;

    localparam logic [15:0] C_COL_MAX = 16'(COL_MAX);
    localparam logic [15:0] C_ROW_MAX = 16'(ROW_MAX);

    state_t            r_state;
    state_t            w_state_nxt;
    logic              r_stop_req;
    logic              w_stop_nxt;
    logic              r_busy;

    logic [DATA_W-1:0] r_data1;
    logic              r_fval1;
    logic              r_lval1;
    logic              r_fval2;
    logic              r_lval2;

    logic [15:0]       r_x;
    logic [15:0]       r_y;
    logic              r_line_acc;

    logic [DATA_W-1:0] r_odata;
    logic              r_odval;
    logic [15:0]       r_ox;
    logic [15:0]       r_oy;
    logic [31:0]       r_frame_cnt;
    logic              r_geom_err;

    logic              w_fval_rise;
    logic              w_fval_fall;
    logic              w_lval_fall;
    logic              w_in_capture;
    logic              w_pix_active;
    logic              w_in_range;
    logic              w_pix_ok;
    logic              w_pix_drop;
    logic              w_start_acc;
    logic              w_frame_end;
    logic [DATA_W-1:0] w_pix_data;

    // Edges are taken between the stage-1 copy and its one-cycle-older value.
    assign w_fval_rise  = r_fval1 & ~r_fval2;
    assign w_fval_fall  = ~r_fval1 & r_fval2;
    assign w_lval_fall  = ~r_lval1 & r_lval2;

    assign w_in_capture = (r_state == CAPTURE);
    assign w_pix_active = r_fval1 & r_lval1 & w_in_capture;
    assign w_in_range   = (r_x < C_COL_MAX) && (r_y < C_ROW_MAX);
    assign w_pix_ok     = w_pix_active & w_in_range;
    assign w_pix_drop   = w_pix_active & ~w_in_range;
    assign w_start_acc  = (r_state == IDLE) & bus.iSTART & ~bus.iEND;
    assign w_frame_end  = w_in_capture & w_fval_fall;

`ifdef CAPTURE_TEST_PATTERN_EN
    logic        r_tp_sel;
    logic [15:0] w_xy_sum;

    assign w_xy_sum   = r_x + r_y;
    assign w_pix_data = r_tp_sel ? DATA_W'(w_xy_sum) : r_data1;

    // Latched only at start of frame so one frame never mixes sources.
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            r_tp_sel <= 1'b0;
        end else if (w_fval_rise) begin
            r_tp_sel <= bus.iTP_SEL;
        end
    end
`else
    assign w_pix_data = r_data1;
`endif

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            r_data1 <= '0;
            r_fval1 <= 1'b0;
            r_lval1 <= 1'b0;
            r_fval2 <= 1'b0;
            r_lval2 <= 1'b0;
        end else begin
            r_data1 <= bus.iDATA;
            r_fval1 <= bus.iFVAL;
            r_lval1 <= bus.iLVAL;
            r_fval2 <= r_fval1;
            r_lval2 <= r_lval1;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_stop_nxt  = r_stop_req;
        case (r_state)
            IDLE: begin
                if (w_start_acc) begin
                    w_state_nxt = WAIT_SOF;
                end
            end
            WAIT_SOF: begin
                if (bus.iEND) begin
                    w_state_nxt = IDLE;
                end else if (w_fval_rise) begin
                    w_state_nxt = CAPTURE;
                end
            end
            CAPTURE: begin
                if (w_fval_fall) begin
                    w_state_nxt = (r_stop_req | bus.iEND) ? IDLE : WAIT_SOF;
                    w_stop_nxt  = 1'b0;
                end else if (bus.iEND) begin
                    w_stop_nxt  = 1'b1;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_stop_nxt  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            r_state    <= IDLE;
            r_stop_req <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_stop_req <= w_stop_nxt;
            r_busy     <= (w_state_nxt != IDLE);
        end
    end

    // Position counters sit at zero outside CAPTURE, so a new frame starts at (0,0).
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            r_x        <= '0;
            r_y        <= '0;
            r_line_acc <= 1'b0;
        end else if (!w_in_capture || w_fval_fall) begin
            r_x        <= '0;
            r_y        <= '0;
            r_line_acc <= 1'b0;
        end else if (w_lval_fall) begin
            r_x        <= '0;
            r_line_acc <= 1'b0;
            if (r_line_acc && (r_y < C_ROW_MAX)) begin
                r_y <= r_y + 16'd1;
            end
        end else if (w_pix_ok) begin
            r_x        <= r_x + 16'd1;
            r_line_acc <= 1'b1;
        end
    end

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            r_odata <= '0;
            r_odval <= 1'b0;
            r_ox    <= '0;
            r_oy    <= '0;
        end else begin
            r_odval <= w_pix_ok;
            if (w_pix_ok) begin
                r_odata <= w_pix_data;
                r_ox    <= r_x;
                r_oy    <= r_y;
            end
        end
    end

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            r_frame_cnt <= '0;
            r_geom_err  <= 1'b0;
        end else begin
            if (w_frame_end) begin
                r_frame_cnt <= r_frame_cnt + 32'd1;
            end
            if (w_start_acc) begin
                r_geom_err <= 1'b0;
            end else if (w_pix_drop) begin
                r_geom_err <= 1'b1;
            end
        end
    end

    assign bus.oDATA       = r_odata;
    assign bus.oDVAL       = r_odval;
    assign bus.oX_Cont     = r_ox;
    assign bus.oY_Cont     = r_oy;
    assign bus.oFrame_Cont = r_frame_cnt;
    assign bus.oBUSY       = r_busy;
    assign bus.oGEOM_ERR   = r_geom_err;
endmodule
